serial_add_sub_unit: RTL and testbench

//   Bit-serial WIDTH-bit add/subtract sequencer built on one full_adder and one

---
 rtl/serial_add_sub_unit.sv | 162 ++++++++++++++++
 tb/tb_serial_add_sub_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub_unit.sv
// Bit-serial add/subtract sequencer: operands are shifted LSB-first through a
// full_adder or full_subtractor cell. Define SERIAL_ADD_SUB_OVF_EN for the ovf port.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (bin & ~(a ^ b));
endmodule

module serial_add_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADD_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: start is accepted only in IDLE or DONE (DONE allows back-to-back);
  // done is a one-cycle pulse; busy marks RUN and any start seen then is dropped.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_shifted;
  logic             carry_q, op_q;
  logic             load, last_bit;
  logic             fa_sum, fa_cout, fs_diff, fs_bout;
  logic             cell_bit, cell_carry;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (carry_q),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  assign cell_bit   = op_q ? fs_diff : fa_sum;
  assign cell_carry = op_q ? fs_bout : fa_cout;
  assign load       = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_bit   = (state_q == S_RUN) && (count_q == CW'(WIDTH - 1));

  // New bit enters at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
  always_comb begin
    res_shifted            = res_sr >> 1;
    res_shifted[WIDTH-1]   = cell_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
      count_q <= '0;
      result  <= '0;
      cout    <= 1'b0;
    end else begin
      if (load) begin
        a_sr    <= a;
        b_sr    <= b;
        op_q    <= op;
        carry_q <= 1'b0;
        count_q <= '0;
      end else if (state_q == S_RUN) begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        res_sr  <= res_shifted;
        carry_q <= cell_carry;
        count_q <= count_q + CW'(1);
      end
      if (last_bit) begin
        result <= res_shifted;
        cout   <= cell_carry;
      end
    end
  end

`ifdef SERIAL_ADD_SUB_OVF_EN
  // Operand sign bits are kept aside because the shift registers lose them.
  logic a_msb, b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (load) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (last_bit)
        ovf <= (op_q ? (a_msb != b_msb) : (a_msb == b_msb)) && (cell_bit != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Self-checking bench for serial_add_sub_unit (WIDTH=8): directed corner cases
// plus randomized operations against an arithmetic reference model.

module tb_serial_add_sub_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

`ifdef SERIAL_ADD_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
  assign ovf = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  serial_add_sub_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on unsigned and two's-complement values.
  function automatic void model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic c, output logic v);
    int sx, sy, sr;
    logic [W:0] wide;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    if (!o) begin
      wide = {1'b0, x} + {1'b0, y};
      r    = wide[W-1:0];
      c    = wide[W];
      sr   = sx + sy;
    end else begin
      r  = x - y;
      c  = (x < y);
      sr = sx - sy;
    end
    v = OVF_EN && ((sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1))));
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts one operation from a negedge and returns at the negedge of the done
  // cycle; dc is the done cycle index counted from the start edge (-1 on timeout).
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int dc, output int bc, output logic [W-1:0] r,
                        output logic c, output logic v);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); a = W'($urandom); b = W'($urandom);
    dc = -1; bc = 0; r = result; c = cout; v = ovf;
    for (int k = 0; k < W + 6; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        dc = k; r = result; c = cout; v = ovf;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(2);
    n_vec++;
    if ({busy, done, result, cout, ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
               busy, done, result, cout, ovf);
    end
    rst_n = 1'b1;
    idle(2);
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    logic         t_op [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] t_a  [4] = '{8'h7F, 8'hFF, 8'h05, 8'h80};
    logic [W-1:0] t_b  [4] = '{8'h01, 8'h01, 8'h07, 8'h01};
    logic [W-1:0] t_r  [4] = '{8'h80, 8'h00, 8'hFE, 8'h7F};
    logic         t_c  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic         t_v  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int dc, bc;
    logic [W-1:0] r;
    logic c, v;
    for (int i = 0; i < 4; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], dc, bc, r, c, v);
      n_vec++;
      if ({r, c, v} !== {t_r[i], t_c[i], t_v[i] & OVF_EN}) begin
        n_bad++;
        $display("FAIL directed_%0d: got result=%h cout=%b ovf=%b, want %h %b %b",
                 i, r, c, v, t_r[i], t_c[i], t_v[i] & OVF_EN);
      end
      n_vec++;
      if (dc !== W || bc !== W) begin
        n_bad++;
        $display("FAIL directed_timing_%0d: got done_at=%0d busy_cycles=%0d, want %0d %0d",
                 i, dc, bc, W, W);
      end
      idle(3);
      n_vec++;
      if (result !== t_r[i] || cout !== t_c[i] || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_%0d: got result=%h cout=%b busy=%b, want %h %b 0",
                 i, result, cout, busy, t_r[i], t_c[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int pulses = 0;
    logic [W-1:0] r = '0;
    start = 1'b1; op = 1'b0; a = 8'h10; b = 8'h20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; op = 1'b1; a = 8'hAA; b = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2 * W + 4; k++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        r = result;
      end
    end
    n_vec++;
    if (pulses !== 1 || r !== 8'h30) begin
      n_bad++;
      $display("FAIL ignore_start: got pulses=%0d result=%h, want 1 30", pulses, r);
    end
  endtask

  task automatic test_back_to_back;
    int dc, bc;
    logic [W-1:0] r;
    logic c, v;
    run_op(1'b1, 8'h03, 8'h01, dc, bc, r, c, v);
    n_vec++;
    if (r !== 8'h02 || c !== 1'b0 || dc !== W) begin
      n_bad++;
      $display("FAIL b2b_first: got result=%h cout=%b done_at=%0d, want 02 0 %0d", r, c, dc, W);
    end
    run_op(1'b0, 8'h02, 8'h02, dc, bc, r, c, v);
    n_vec++;
    if (r !== 8'h04 || c !== 1'b0 || dc !== W || bc !== W) begin
      n_bad++;
      $display("FAIL b2b_second: got result=%h cout=%b done_at=%0d busy=%0d, want 04 0 %0d %0d",
               r, c, dc, bc, W, W);
    end
    idle(1);
  endtask

  task automatic test_reset_mid_run;
    int pulses = 0;
    int dc, bc;
    logic [W-1:0] r;
    logic c, v;
    start = 1'b1; op = 1'b0; a = 8'hF0; b = 8'h0F;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, result, cout} !== '0) begin
      n_bad++;
      $display("FAIL mid_run_reset: got busy=%b done=%b result=%h cout=%b, want all 0",
               busy, done, result, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL aborted_done: got %0d done pulses, want 0", pulses);
    end
    run_op(1'b0, 8'h01, 8'h01, dc, bc, r, c, v);
    n_vec++;
    if (r !== 8'h02 || c !== 1'b0 || dc !== W) begin
      n_bad++;
      $display("FAIL after_reset_op: got result=%h cout=%b done_at=%0d, want 02 0 %0d", r, c, dc, W);
    end
    idle(1);
  endtask

  task automatic test_random;
    logic [W-1:0] corner [4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};
    int dc, bc;
    logic [W-1:0] x, y, r, er;
    logic o, c, v, ec, ev;
    for (int i = 0; i < 60; i++) begin
      o = 1'($urandom);
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      model(o, x, y, er, ec, ev);
      run_op(o, x, y, dc, bc, r, c, v);
      n_vec++;
      if ({r, c, v} !== {er, ec, ev} || dc !== W) begin
        n_bad++;
        $display("FAIL random_%0d op=%b a=%h b=%h: got result=%h cout=%b ovf=%b done_at=%0d, want %h %b %b %0d",
                 i, o, x, y, r, c, v, dc, er, ec, ev, W);
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
